// File: rtl/fifo_rd_packer_pkg.sv
// ---------------------------------------------------------------------------
// fifo_rd_packer_pkg
//
// Shared definitions for the FIFO read-side packer:
//   DEFAULT_FIFO_WIDTH  - default width of one FIFO word
//   DEFAULT_PACK_RATIO  - default number of FIFO words per packed word
//   packer_state_e      - packer FSM states
//   fill_width()        - width of a counter that must hold 0..ratio
// ---------------------------------------------------------------------------
package fifo_rd_packer_pkg;

    localparam int DEFAULT_FIFO_WIDTH = 16;
    localparam int DEFAULT_PACK_RATIO = 4;

    // PK_FILL  : accumulating FIFO words into lanes
    // PK_HOLD  : accumulator full, waiting for the output register to free
    // PK_FLUSH : partial word closed by flush, waiting for the output register
    typedef enum logic [1:0] {
        PK_FILL  = 2'd0,
        PK_HOLD  = 2'd1,
        PK_FLUSH = 2'd2
    } packer_state_e;

    // The fill counter must represent the value "ratio" itself (full), so it
    // needs one more code than a plain lane index.
    function automatic int fill_width(input int ratio);
        return $clog2(ratio + 1);
    endfunction

endpackage

// File: rtl/fifo_rd_packer_acc.sv
// ---------------------------------------------------------------------------
// fifo_rd_packer_acc
//
// Lane accumulator for the FIFO read packer. Holds PACK_RATIO lanes of
// FIFO_WIDTH bits and a fill counter. A captured word is written to
// lane[fill]. The "merged" outputs show the accumulator as it will look
// after the capture of the current cycle, so the owner can move a word to
// its output register on the same edge the last lane lands.
//
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   capture        - write capture_data into lane[fill] this edge
//   capture_data   - FIFO word to capture
//   clear          - empty the accumulator this edge (overrides capture)
//   fill           - registered number of occupied lanes
//   merged_fill    - fill including this cycle's capture
//   merged_word    - lanes including this cycle's capture, lane 0 in LSBs
//   merged_mask    - bit i set when lane i of merged_word holds data
// ---------------------------------------------------------------------------
module fifo_rd_packer_acc
    import fifo_rd_packer_pkg::*;
#(
    parameter int FIFO_WIDTH = DEFAULT_FIFO_WIDTH,
    parameter int PACK_RATIO = DEFAULT_PACK_RATIO,
    localparam int FILL_W    = fill_width(PACK_RATIO)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             capture,
    input  logic [FIFO_WIDTH-1:0]            capture_data,
    input  logic                             clear,
    output logic [FILL_W-1:0]                fill,
    output logic [FILL_W-1:0]                merged_fill,
    output logic [PACK_RATIO*FIFO_WIDTH-1:0] merged_word,
    output logic [PACK_RATIO-1:0]            merged_mask
);

    localparam int IDX_W = $clog2(PACK_RATIO);

    logic [PACK_RATIO-1:0][FIFO_WIDTH-1:0] lanes;
    logic [PACK_RATIO-1:0][FIFO_WIDTH-1:0] merged_lanes;
    logic [IDX_W-1:0]                      lane_idx;

    // The issue rule never lets a capture arrive while the accumulator is
    // full, so the low bits of fill are always a valid lane index here.
    assign lane_idx = fill[IDX_W-1:0];

    // Lanes are zeroed on clear so that a later partial word carries zeros
    // in its unused lanes without any extra masking on the output path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lanes <= '0;
            fill  <= '0;
        end else if (clear) begin
            lanes <= '0;
            fill  <= '0;
        end else if (capture) begin
            lanes[lane_idx] <= capture_data;
            fill            <= merged_fill;
        end
    end

    assign merged_fill = fill + FILL_W'(capture);

    always_comb begin
        merged_lanes = lanes;
        if (capture) begin
            merged_lanes[lane_idx] = capture_data;
        end
    end

    assign merged_word = merged_lanes;

    // Lanes below the fill count are occupied: mask = (1 << fill) - 1.
    always_comb begin
        merged_mask = '0;
        for (int i = 0; i < PACK_RATIO; i++) begin
            merged_mask[i] = (i < int'(merged_fill));
        end
    end

endmodule

// File: rtl/fifo_rd_packer.sv
// ---------------------------------------------------------------------------
// fifo_rd_packer
//
// Consumer of a synchronous FIFO read port. Requests words only when the
// FIFO is non-empty and the accumulator has room for every word already in
// flight, captures the read data one cycle later, and packs PACK_RATIO words
// into one wide word offered on a valid/ready output. A flush pulse closes a
// partial word and emits it with a lane mask.
//
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   fifo_data_out  - FIFO read data, valid the cycle after an accepted rd_en
//   fifo_empty     - FIFO empty flag
//   fifo_rd_en     - FIFO read request (combinational)
//   flush          - single-cycle request to emit the partial word
//   out_data       - packed word, lane 0 (oldest FIFO word) in the LSBs
//   out_mask       - bit i set when lane i holds valid data
//   out_valid      - out_data/out_mask valid
//   out_ready      - consumer accepts when out_valid && out_ready
//   busy           - any word accumulating, in flight, pending or offered
// ---------------------------------------------------------------------------
module fifo_rd_packer
    import fifo_rd_packer_pkg::*;
#(
    parameter int FIFO_WIDTH = DEFAULT_FIFO_WIDTH,
    parameter int PACK_RATIO = DEFAULT_PACK_RATIO
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [FIFO_WIDTH-1:0]            fifo_data_out,
    input  logic                             fifo_empty,
    output logic                             fifo_rd_en,
    input  logic                             flush,
    output logic [FIFO_WIDTH*PACK_RATIO-1:0] out_data,
    output logic [PACK_RATIO-1:0]            out_mask,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             busy
);

    localparam int                FILL_W    = fill_width(PACK_RATIO);
    localparam logic [FILL_W-1:0] FULL_FILL = FILL_W'(PACK_RATIO);
    localparam logic [FILL_W:0]   RATIO_EXT = (FILL_W + 1)'(PACK_RATIO);

    packer_state_e                    state;
    logic                             inflight;
    logic                             flush_pend;

    logic [FILL_W-1:0]                fill;
    logic [FILL_W-1:0]                merged_fill;
    logic [FIFO_WIDTH*PACK_RATIO-1:0] merged_word;
    logic [PACK_RATIO-1:0]            merged_mask;

    logic [FILL_W:0]                  demand;
    logic                             slot_free;
    logic                             merged_full;
    logic                             resolve_flush;
    logic                             load_word;

    fifo_rd_packer_acc #(
        .FIFO_WIDTH (FIFO_WIDTH),
        .PACK_RATIO (PACK_RATIO)
    ) u_acc (
        .clk          (clk),
        .rst_n        (rst_n),
        .capture      (inflight),
        .capture_data (fifo_data_out),
        .clear        (load_word),
        .fill         (fill),
        .merged_fill  (merged_fill),
        .merged_word  (merged_word),
        .merged_mask  (merged_mask)
    );

    // Lanes already claimed: captured words plus the word still in flight.
    // A read is only issued when it is guaranteed a lane, which also blocks
    // reads in PK_HOLD (fill is full) and PK_FLUSH (flush_pend is set).
    // rst_n gates the request so reset drops it without waiting for an edge.
    assign demand     = {1'b0, fill} + {{FILL_W{1'b0}}, inflight};
    assign fifo_rd_en = rst_n && !fifo_empty && !flush_pend && (demand < RATIO_EXT);

    assign slot_free     = !out_valid || out_ready;
    assign merged_full   = (merged_fill == FULL_FILL);
    assign resolve_flush = flush_pend && !inflight;

    // A word moves to the output register when the slot is free and either
    // the accumulator completes this edge, a word is already waiting in
    // PK_HOLD/PK_FLUSH, or a pending flush finds a non-empty accumulator.
    // Completion uses the merged view, so the last lane and the transfer
    // share one edge.
    assign load_word = slot_free &&
                       ((state != PK_FILL) || merged_full ||
                        (resolve_flush && (merged_fill != '0)));

    assign busy = (fill != '0) || inflight || out_valid || flush_pend;

    // A flush that finds a full accumulator emits it with an all-ones mask,
    // which falls out of the same mask generation as the partial case.
    // A flush pulse while one is already pending is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= PK_FILL;
            inflight   <= 1'b0;
            flush_pend <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_mask   <= '0;
        end else begin
            inflight <= fifo_rd_en;

            if (load_word) begin
                out_valid <= 1'b1;
                out_data  <= merged_word;
                out_mask  <= merged_mask;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (flush_pend) begin
                if (resolve_flush && ((merged_fill == '0) || load_word)) begin
                    flush_pend <= 1'b0;
                end
            end else begin
                flush_pend <= flush;
            end

            if (load_word) begin
                state <= PK_FILL;
            end else if (merged_full) begin
                state <= PK_HOLD;
            end else if (resolve_flush && (merged_fill != '0)) begin
                state <= PK_FLUSH;
            end else begin
                state <= PK_FILL;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// ---------------------------------------------------------------------------
// tb_fifo_rd_packer
//
// Randomized and directed stimulus for fifo_rd_packer. A behavioural FIFO
// answers the packer's read requests; every word it hands out is appended to
// the current group of the reference model, groups close at PACK_RATIO words
// or on flush, and each closed group is queued as an expected output word.
// A monitor compares every accepted output word against that queue.
// ---------------------------------------------------------------------------
module tb_fifo_rd_packer;

    localparam int FW = 16;
    localparam int PR = 4;
    localparam int OW = FW * PR;

    typedef struct {
        logic [OW-1:0] data;
        logic [PR-1:0] mask;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [FW-1:0] fifo_data_out = '0;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_en;
    logic          flush = 1'b0;
    logic [OW-1:0] out_data;
    logic [PR-1:0] out_mask;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          busy;

    exp_t          exp_q[$];
    logic [FW-1:0] fifo_q[$];
    logic [FW-1:0] group_q[$];
    logic [FW-1:0] pop_word;
    logic [FW-1:0] fresh[4];

    int  checks = 0;
    int  errors = 0;
    int  pops = 0;
    bit  toggle_mode = 1'b0;
    bit  empty_force = 1'b0;

    always #5 clk = ~clk;

    fifo_rd_packer #(
        .FIFO_WIDTH (FW),
        .PACK_RATIO (PR)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fifo_data_out (fifo_data_out),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .flush         (flush),
        .out_data      (out_data),
        .out_mask      (out_mask),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy)
    );

    // Reference model: close the current group into one expected word.
    task automatic closeGroup();
        exp_t e;
        if (group_q.size() > 0) begin
            e.data = '0;
            for (int i = 0; i < group_q.size(); i++) begin
                e.data[i*FW +: FW] = group_q[i];
            end
            e.mask = PR'((1 << group_q.size()) - 1);
            exp_q.push_back(e);
            group_q.delete();
        end
    endtask

    // Behavioural FIFO read port plus reference model feed.
    always @(posedge clk) begin
        checks++;
        if (fifo_rd_en && fifo_empty) begin
            errors++;
            $display("[TB] FAIL rd_en_while_empty: fifo_rd_en=%0b fifo_empty=%0b, required fifo_rd_en=0",
                     fifo_rd_en, fifo_empty);
        end
        if (fifo_rd_en && !fifo_empty && fifo_q.size() > 0) begin
            pop_word = fifo_q.pop_front();
            fifo_data_out <= pop_word;
            pops++;
            group_q.push_back(pop_word);
            if (group_q.size() == PR) begin
                closeGroup();
            end
        end
        if (flush && rst_n) begin
            closeGroup();
        end
    end

    // Empty flag is refreshed away from the active edge.
    always @(negedge clk) begin
        if (toggle_mode) begin
            empty_force = !empty_force;
        end else begin
            empty_force = 1'b0;
        end
        fifo_empty = (fifo_q.size() == 0) || empty_force;
    end

    // Scoreboard monitor: a handshake seen at the negedge completes at the
    // following posedge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_word: got data=0x%h mask=0x%h, required no output",
                         out_data, out_mask);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e.data || out_mask !== e.mask) begin
                    errors++;
                    $display("[TB] FAIL scoreboard_word: got data=0x%h mask=0x%h, required data=0x%h mask=0x%h",
                             out_data, out_mask, e.data, e.mask);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [OW-1:0] actual,
                               input logic [OW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic pushWord(input logic [FW-1:0] w);
        fifo_q.push_back(w);
    endtask

    task automatic applyStimulus(input bit rdy, input bit fl, input int npush);
        stepCycle();
        out_ready = rdy;
        flush = fl;
        for (int i = 0; i < npush; i++) begin
            pushWord(FW'($urandom));
        end
    endtask

    task automatic assertReset();
        rst_n = 1'b0;
        fifo_q.delete();
        group_q.delete();
        exp_q.delete();
    endtask

    task automatic waitValid(input string name, input int budget);
        int n = 0;
        while (!out_valid && n < budget) begin
            stepCycle();
            n++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: out_valid=0 after %0d cycles, required 1", name, budget);
        end
    endtask

    task automatic waitIdle(input string name, input int budget);
        int n = 0;
        while (!(busy == 1'b0 && fifo_q.size() == 0) && n < budget) begin
            stepCycle();
            n++;
        end
        checks++;
        if (busy !== 1'b0 || fifo_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s: busy=%0b fifo_words=%0d after %0d cycles, required busy=0 fifo_words=0",
                     name, busy, fifo_q.size(), budget);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int p0;
        int n;

        // Reset with a preloaded FIFO, then the first packed word.
        rst_n = 1'b0;
        repeat (2) stepCycle();
        for (int i = 1; i <= 4; i++) pushWord(FW'(i));
        repeat (3) stepCycle();
        checkOutput("reset_rd_en", OW'(fifo_rd_en), '0);
        checkOutput("reset_out_valid", OW'(out_valid), '0);
        checkOutput("reset_out_data", out_data, '0);
        checkOutput("reset_out_mask", OW'(out_mask), '0);
        checkOutput("reset_busy", OW'(busy), '0);
        out_ready = 1'b1;
        rst_n = 1'b1;
        lat = 0;
        while (!out_valid && lat < 20) begin
            stepCycle();
            lat++;
        end
        checkOutput("t1_latency_le6", OW'(lat <= 6), OW'(1));
        checkOutput("t1_data", out_data, 64'h0004_0003_0002_0001);
        checkOutput("t1_mask", OW'(out_mask), OW'(4'hF));
        waitIdle("t1_idle", 40);

        // Backpressure: two words, the second held until the slot frees.
        out_ready = 1'b0;
        p0 = pops;
        for (int i = 0; i < 8; i++) pushWord(FW'(16'h0011 + i));
        repeat (14) stepCycle();
        checkOutput("t2_pops", OW'(pops - p0), OW'(8));
        checkOutput("t2_rd_en_held", OW'(fifo_rd_en), '0);
        checkOutput("t2_first_valid", OW'(out_valid), OW'(1));
        checkOutput("t2_first_data", out_data, 64'h0014_0013_0012_0011);
        out_ready = 1'b1;
        stepCycle();
        checkOutput("t2_second_valid", OW'(out_valid), OW'(1));
        checkOutput("t2_second_data", out_data, 64'h0018_0017_0016_0015);
        checkOutput("t2_second_mask", OW'(out_mask), OW'(4'hF));
        waitIdle("t2_idle", 40);

        // Flush of a two-lane partial word.
        pushWord(16'hAAAA);
        pushWord(16'hBBBB);
        repeat (5) stepCycle();
        flush = 1'b1;
        stepCycle();
        waitValid("t3_valid", 10);
        checkOutput("t3_data", out_data, 64'h0000_0000_BBBB_AAAA);
        checkOutput("t3_mask", OW'(out_mask), OW'(4'b0011));
        waitIdle("t3_idle", 20);

        // Empty flag toggling every cycle.
        toggle_mode = 1'b1;
        for (int i = 0; i < 4; i++) pushWord(16'h1234);
        waitValid("t4_valid", 40);
        checkOutput("t4_data", out_data, 64'h1234_1234_1234_1234);
        checkOutput("t4_mask", OW'(out_mask), OW'(4'hF));
        toggle_mode = 1'b0;
        waitIdle("t4_idle", 40);

        // Reset mid-fill, then reset with a word on the output.
        for (int i = 0; i < 8; i++) pushWord(FW'($urandom));
        p0 = pops;
        n = 0;
        while (pops - p0 < 3 && n < 20) begin
            stepCycle();
            n++;
        end
        assertReset();
        #1;
        checkOutput("t5a_out_valid", OW'(out_valid), '0);
        checkOutput("t5a_rd_en", OW'(fifo_rd_en), '0);
        checkOutput("t5a_busy", OW'(busy), '0);
        repeat (2) stepCycle();
        out_ready = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) pushWord(FW'($urandom));
        waitValid("t5b_valid", 20);
        assertReset();
        #1;
        checkOutput("t5b_out_valid", OW'(out_valid), '0);
        checkOutput("t5b_out_data", out_data, '0);
        checkOutput("t5b_out_mask", OW'(out_mask), '0);
        repeat (2) stepCycle();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fresh[i] = FW'($urandom);
            pushWord(fresh[i]);
        end
        waitValid("t5c_valid", 20);
        checkOutput("t5c_data", out_data, {fresh[3], fresh[2], fresh[1], fresh[0]});
        waitIdle("t5_idle", 40);

        // Flush with an empty accumulator.
        checkOutput("t6_idle_before", OW'(busy), '0);
        flush = 1'b1;
        stepCycle();
        checkOutput("t6_busy_pending", OW'(busy), OW'(1));
        stepCycle();
        checkOutput("t6_busy_cleared", OW'(busy), '0);
        checkOutput("t6_no_output", OW'(out_valid), '0);

        // Randomized traffic with random backpressure and flushes.
        for (int c = 0; c < 600; c++) begin
            applyStimulus(($urandom % 4) != 0, ($urandom % 40) == 0,
                          (($urandom % 2) == 0) ? 1 : 0);
        end
        out_ready = 1'b1;
        n = 0;
        while (fifo_q.size() > 0 && n < 400) begin
            stepCycle();
            n++;
        end
        repeat (8) stepCycle();
        flush = 1'b1;
        stepCycle();
        waitIdle("rand_drain", 60);
        checkOutput("rand_pending_words", OW'(exp_q.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
